// File: rtl/dsp48a1_mac_sequencer.sv
// Feeds signed operand pairs into a DSP48A1 configured as a multiply-accumulator and
// returns the vector sum once the DSP pipeline has drained.
module dsp48a1_mac_sequencer #(
  parameter int DSP_PIPE = 3,
  parameter int MAX_LEN  = 256,
  parameter int CNT_W    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic [CNT_W-1:0] res_count,
  output logic             res_trunc,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [17:0]      dsp_d,
  output logic [47:0]      dsp_c,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_carryin,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_ceopmode,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p
);

  localparam int DW = $clog2(DSP_PIPE + 1);

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, CAPTURE, HOLD} state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [DW-1:0]       drain_cnt;
  logic [DSP_PIPE-1:0] vld_pipe;
  logic                first_slot;
  logic                trunc_flag;
  logic                hs;
  logic                last_elem;

  assign hs        = in_valid && in_ready;
  assign last_elem = in_last || (count == CNT_W'(MAX_LEN - 1));

  // Each valid slot walks down vld_pipe; its position selects which DSP stage is enabled.
  assign dsp_cea     = vld_pipe[0];
  assign dsp_ceb     = vld_pipe[0];
  assign dsp_cem     = vld_pipe[1];
  assign dsp_cep     = vld_pipe[DSP_PIPE-1];
  assign dsp_d       = '0;
  assign dsp_c       = '0;
  assign dsp_carryin = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_count    <= '0;
      res_trunc    <= 1'b0;
      dsp_a        <= '0;
      dsp_b        <= '0;
      dsp_opmode   <= '0;
      dsp_ceopmode <= 1'b0;
      dsp_rst      <= 1'b1;
      count        <= '0;
      drain_cnt    <= '0;
      vld_pipe     <= '0;
      first_slot   <= 1'b0;
      trunc_flag   <= 1'b0;
    end else begin
      dsp_rst      <= 1'b0;
      dsp_ceopmode <= 1'b1;
      vld_pipe     <= {vld_pipe[DSP_PIPE-2:0], hs};
      first_slot   <= hs && (count == '0);
      // First element of a vector loads P with M alone; later ones accumulate onto P.
      dsp_opmode   <= first_slot ? 8'h01 : 8'h09;
      if (hs) begin
        dsp_a <= in_a;
        dsp_b <= in_b;
      end

      case (state)
        IDLE: begin
          state    <= FEED;
          in_ready <= 1'b1;
        end
        FEED: begin
          if (hs) begin
            count <= count + CNT_W'(1);
            if (last_elem) begin
              state      <= DRAIN;
              in_ready   <= 1'b0;
              trunc_flag <= !in_last;
              drain_cnt  <= DW'(DSP_PIPE);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= CAPTURE;
          else drain_cnt <= drain_cnt - DW'(1);
        end
        CAPTURE: begin
          res_data  <= dsp_p;
          res_count <= count;
          res_trunc <= trunc_flag;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            count     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
